// File: rtl/write_resp_controller_pkg.sv
// Shared types for the write-response controller.
// BRESP encodings, queue pointer sizing.
package write_resp_controller_pkg;

  typedef enum logic [1:0] {
    BRESP_OKAY   = 2'b00,
    BRESP_EXOKAY = 2'b01,
    BRESP_SLVERR = 2'b10,
    BRESP_DECERR = 2'b11
  } bresp_e;

  localparam int QDEPTH_DEF = 4;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int QPTR_W = ptr_w(QDEPTH_DEF);

  typedef logic [QPTR_W-1:0] qptr_t;

endpackage

// File: rtl/write_resp_controller_if.sv
// AW-order push and B-channel bundle.
// slave: the controller view, master: environment view.
interface write_resp_controller_if #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 2,
  parameter int ID_W        = $clog2(NUM_SLAVES),
  parameter int MID_W       = $clog2(NUM_MASTERS)
);

  logic                     aw_push;
  logic [MID_W-1:0]         aw_push_master;
  logic [ID_W-1:0]          aw_push_slave;
  logic [2*NUM_SLAVES-1:0]  m_bresp;
  logic [NUM_SLAVES-1:0]    m_bvalid;
  logic [NUM_SLAVES-1:0]    m_bready;
  logic [2*NUM_MASTERS-1:0] s_bresp;
  logic [NUM_MASTERS-1:0]   s_bvalid;
  logic [NUM_MASTERS-1:0]   s_bready;

  modport slave (
    input  aw_push,
    input  aw_push_master,
    input  aw_push_slave,
    input  m_bresp,
    input  m_bvalid,
    output m_bready,
    output s_bresp,
    output s_bvalid,
    input  s_bready
  );

  modport master (
    output aw_push,
    output aw_push_master,
    output aw_push_slave,
    output m_bresp,
    output m_bvalid,
    input  m_bready,
    input  s_bresp,
    input  s_bvalid,
    output s_bready
  );

endinterface

// File: rtl/wresp_order_fifo.sv
// Per-slave queue of master indices in AW order.
// Pointers carry an extra wrap bit for full/empty.
module wresp_order_fifo
  import write_resp_controller_pkg::*;
#(
  parameter int DEPTH = QDEPTH_DEF,
  parameter int DW    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          wr_en;
  logic          rd_en;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign wr_en = push_i && !full_o;
  assign rd_en = pop_i && !empty_o;

  assign wr_d = wr_q + PW'(wr_en);
  assign rd_d = rd_q + PW'(rd_en);

  assign head_o = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (wr_en) begin
        mem_q[wr_q[AW-1:0]] <= din_i;
      end
    end
  end

endmodule

// File: rtl/write_resp_controller.sv
// Routes per-slave B responses to masters in AW order.
// Option WRESP_UNEXP_DROP_EN: drop unexpected B, flag unexp_b_err.
module write_resp_controller
  import write_resp_controller_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 2,
  parameter int ID_W        = $clog2(NUM_SLAVES),
  parameter int MID_W       = $clog2(NUM_MASTERS),
  parameter int QDEPTH      = QDEPTH_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  write_resp_controller_if.slave bus,
  output logic       Queue_Is_Full,
  output logic [3:0] Num_Of_Compl_Bursts
`ifdef WRESP_UNEXP_DROP_EN
  ,
  output logic       unexp_b_err
`endif
);

  logic [MID_W-1:0]       head [NUM_SLAVES];
  logic [1:0]             sresp [NUM_SLAVES];
  logic [NUM_SLAVES-1:0]  empty;
  logic [NUM_SLAVES-1:0]  full;
  logic [NUM_SLAVES-1:0]  push;
  logic [NUM_SLAVES-1:0]  pop;
  logic [NUM_SLAVES-1:0]  mready;
  logic [NUM_SLAVES-1:0]  cand [NUM_MASTERS];

  logic [NUM_MASTERS-1:0] win_vld;
  logic [ID_W-1:0]        win_idx [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] free;
  logic [NUM_MASTERS-1:0] load;
  logic [NUM_MASTERS-1:0] drain;

  logic [ID_W-1:0]        rr_q [NUM_MASTERS];
  logic [ID_W-1:0]        rr_d [NUM_MASTERS];
  logic [1:0]             bresp_q [NUM_MASTERS];
  logic [1:0]             bresp_d [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] bvalid_q, bvalid_d;
  logic [3:0]             cnt_q, cnt_d;

  for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_q
    assign push[s] = bus.aw_push &&
                     (bus.aw_push_slave == ID_W'(s));
    assign sresp[s] = bus.m_bresp[2*s +: 2];

    wresp_order_fifo #(
      .DEPTH (QDEPTH),
      .DW    (MID_W)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (reset_n),
      .push_i  (push[s]),
      .din_i   (bus.aw_push_master),
      .pop_i   (pop[s]),
      .head_o  (head[s]),
      .empty_o (empty[s]),
      .full_o  (full[s])
    );
  end

  always_comb begin
    for (int m = 0; m < NUM_MASTERS; m++) begin
      for (int s = 0; s < NUM_SLAVES; s++) begin
        cand[m][s] = bus.m_bvalid[s] && !empty[s] &&
                     (head[s] == MID_W'(m));
      end
    end
  end

  // Search starts at rr_q, which already points past the last winner.
  always_comb begin
    for (int m = 0; m < NUM_MASTERS; m++) begin
      win_vld[m] = 1'b0;
      win_idx[m] = '0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
        int idx;
        idx = (int'(rr_q[m]) + k) % NUM_SLAVES;
        if (!win_vld[m] && cand[m][idx]) begin
          win_vld[m] = 1'b1;
          win_idx[m] = ID_W'(idx);
        end
      end
    end
  end

  always_comb begin
    for (int m = 0; m < NUM_MASTERS; m++) begin
      drain[m] = bvalid_q[m] && bus.s_bready[m];
      free[m]  = !bvalid_q[m] || bus.s_bready[m];
      load[m]  = win_vld[m] && free[m];
    end
  end

  always_comb begin
    mready = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if (load[m] && (win_idx[m] == ID_W'(s))) begin
          mready[s] = 1'b1;
        end
      end
`ifdef WRESP_UNEXP_DROP_EN
      if (bus.m_bvalid[s] && empty[s]) begin
        mready[s] = 1'b1;
      end
`endif
    end
  end

  assign bus.m_bready = mready;
  assign pop = bus.m_bvalid & mready & ~empty;

  always_comb begin
    cnt_d    = cnt_q;
    bvalid_d = bvalid_q;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      rr_d[m]    = rr_q[m];
      bresp_d[m] = bresp_q[m];
      if (drain[m]) begin
        bvalid_d[m] = 1'b0;
        cnt_d       = cnt_d + 4'd1;
      end
      if (load[m]) begin
        bvalid_d[m] = 1'b1;
        bresp_d[m]  = sresp[win_idx[m]];
        if (int'(win_idx[m]) == NUM_SLAVES - 1) begin
          rr_d[m] = '0;
        end else begin
          rr_d[m] = win_idx[m] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bvalid_q <= '0;
      cnt_q    <= '0;
      for (int m = 0; m < NUM_MASTERS; m++) begin
        rr_q[m]    <= '0;
        bresp_q[m] <= BRESP_OKAY;
      end
    end else begin
      bvalid_q <= bvalid_d;
      cnt_q    <= cnt_d;
      for (int m = 0; m < NUM_MASTERS; m++) begin
        rr_q[m]    <= rr_d[m];
        bresp_q[m] <= bresp_d[m];
      end
    end
  end

  for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_out
    assign bus.s_bresp[2*m +: 2] = bresp_q[m];
  end

  assign bus.s_bvalid        = bvalid_q;
  assign Queue_Is_Full       = |full;
  assign Num_Of_Compl_Bursts = cnt_q;

`ifdef WRESP_UNEXP_DROP_EN
  logic err_q, err_d;

  assign err_d = err_q |
                 (|(bus.m_bvalid & mready & empty));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign unexp_b_err = err_q;
`endif

endmodule

// File: tb/tb_write_resp_controller.sv
// Scoreboard bench for write_resp_controller.
// Handles both WRESP_UNEXP_DROP_EN builds.
`timescale 1ns/1ps
module tb_write_resp_controller;

  localparam int NM = 2;
  localparam int NS = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       qfull;
  logic [3:0] ncnt;
`ifdef WRESP_UNEXP_DROP_EN
  logic       unexp_b_err;
`endif

  int checks = 0;
  int failures = 0;
  logic [1:0] exp0 [$];
  logic [1:0] exp1 [$];
  logic [1:0] seq [4];

  always #5 clk = ~clk;

  write_resp_controller_if #(
    .NUM_MASTERS (NM),
    .NUM_SLAVES  (NS),
    .ID_W        (1),
    .MID_W       (1)
  ) bus ();

  write_resp_controller #(
    .NUM_MASTERS (NM),
    .NUM_SLAVES  (NS),
    .ID_W        (1),
    .MID_W       (1),
    .QDEPTH      (4)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .bus                 (bus),
    .Queue_Is_Full       (qfull),
    .Num_Of_Compl_Bursts (ncnt)
`ifdef WRESP_UNEXP_DROP_EN
    ,
    .unexp_b_err         (unexp_b_err)
`endif
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int m, input int s);
    bus.aw_push        = 1'b1;
    bus.aw_push_master = 1'(m);
    bus.aw_push_slave  = 1'(s);
    cyc();
    bus.aw_push = 1'b0;
  endtask

  // Monitor: every master-side handshake pops the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.s_bvalid[0] && bus.s_bready[0]) begin
        if (exp0.size() == 0)
          chk("m0_unexpected", 32'(bus.s_bvalid[0]), 0);
        else
          chk("m0_bresp", 32'(bus.s_bresp[1:0]),
              32'(exp0.pop_front()));
      end
      if (bus.s_bvalid[1] && bus.s_bready[1]) begin
        if (exp1.size() == 0)
          chk("m1_unexpected", 32'(bus.s_bvalid[1]), 0);
        else
          chk("m1_bresp", 32'(bus.s_bresp[3:2]),
              32'(exp1.pop_front()));
      end
    end
  end

  initial begin
    bus.aw_push        = 1'b0;
    bus.aw_push_master = 1'b0;
    bus.aw_push_slave  = 1'b0;
    bus.m_bresp        = '0;
    bus.m_bvalid       = '0;
    bus.s_bready       = 2'b11;

    // Reset state
    #1 reset_n = 1'b0;
    #1;
    chk("rst_svalid", 32'(bus.s_bvalid), 0);
    chk("rst_sresp", 32'(bus.s_bresp), 0);
    chk("rst_mready", 32'(bus.m_bready), 0);
    chk("rst_qfull", 32'(qfull), 0);
    chk("rst_cnt", 32'(ncnt), 0);
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();

    // Basic route M1<-S0 with one-cycle latency
    push(1, 0);
    bus.m_bvalid[0] = 1'b1;
    bus.m_bresp[1:0] = 2'b00;
    #1 chk("t1_mready", 32'(bus.m_bready[0]), 1);
    exp1.push_back(2'b00);
    cyc();
    bus.m_bvalid[0] = 1'b0;
    chk("t1_svalid1", 32'(bus.s_bvalid[1]), 1);
    chk("t1_svalid0", 32'(bus.s_bvalid[0]), 0);
    cyc();
    chk("t1_cnt", 32'(ncnt), 1);
    chk("t1_drained", 32'(bus.s_bvalid), 0);

    // Push to empty queue is not poppable the same cycle
    bus.aw_push        = 1'b1;
    bus.aw_push_master = 1'b0;
    bus.aw_push_slave  = 1'b0;
    bus.m_bresp[1:0]   = 2'b01;
`ifndef WRESP_UNEXP_DROP_EN
    bus.m_bvalid[0] = 1'b1;
    #1 chk("t1b_no_bypass", 32'(bus.m_bready[0]), 0);
`endif
    cyc();
    bus.aw_push = 1'b0;
    bus.m_bvalid[0] = 1'b1;
    #1 chk("t1b_pop", 32'(bus.m_bready[0]), 1);
    exp0.push_back(2'b01);
    cyc();
    bus.m_bvalid[0] = 1'b0;
    cyc();
    cyc();
    chk("t1b_cnt", 32'(ncnt), 2);

    // Queue full, ignored fifth push, full clears after pop
    for (int i = 0; i < 4; i++) push(0, 1);
    chk("t2_full", 32'(qfull), 1);
    bus.aw_push        = 1'b1;
    bus.aw_push_master = 1'b1;
    bus.aw_push_slave  = 1'b1;
    cyc();
    bus.aw_push = 1'b0;
    chk("t2_full_hold", 32'(qfull), 1);
    seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    for (int i = 0; i < 4; i++) begin
      bus.m_bvalid[1] = 1'b1;
      bus.m_bresp[3:2] = seq[i];
      #1 chk("t2_mready", 32'(bus.m_bready[1]), 1);
      exp0.push_back(seq[i]);
      cyc();
      if (i == 0) chk("t2_unfull", 32'(qfull), 0);
    end
`ifndef WRESP_UNEXP_DROP_EN
    #1 chk("t2_empty_stall", 32'(bus.m_bready[1]), 0);
`endif
    bus.m_bvalid[1] = 1'b0;
    cyc();
    cyc();
    chk("t2_cnt", 32'(ncnt), 6);

    // Round-robin between S0 and S1 both owing M0
    push(0, 0);
    push(0, 1);
    push(0, 0);
    push(0, 1);
    bus.m_bvalid = 2'b11;
    bus.m_bresp  = 4'b10_01;
    #1 chk("t3_rr_a", 32'(bus.m_bready), 32'b01);
    exp0.push_back(2'b01);
    cyc();
    chk("t3_rr_b", 32'(bus.m_bready), 32'b10);
    exp0.push_back(2'b10);
    cyc();
    chk("t3_rr_c", 32'(bus.m_bready), 32'b01);
    exp0.push_back(2'b01);
    cyc();
    chk("t3_rr_d", 32'(bus.m_bready), 32'b10);
    exp0.push_back(2'b10);
    cyc();
    bus.m_bvalid = 2'b00;
    cyc();
    cyc();
    chk("t3_cnt", 32'(ncnt), 10);

    // Backpressure holds response and blocks the winner
    bus.s_bready[0] = 1'b0;
    push(0, 0);
    push(0, 0);
    push(0, 0);
    bus.m_bvalid[0] = 1'b1;
    bus.m_bresp[1:0] = 2'b11;
    #1 chk("t4_first", 32'(bus.m_bready[0]), 1);
    exp0.push_back(2'b11);
    cyc();
    bus.m_bresp[1:0] = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_hold_mready", 32'(bus.m_bready[0]), 0);
      chk("t4_hold_sresp", 32'(bus.s_bresp[1:0]), 32'b11);
      chk("t4_hold_svalid", 32'(bus.s_bvalid[0]), 1);
      cyc();
    end
    bus.s_bready[0] = 1'b1;
    #1 chk("t4_rel_a", 32'(bus.m_bready[0]), 1);
    exp0.push_back(2'b10);
    cyc();
    bus.m_bresp[1:0] = 2'b01;
    #1 chk("t4_rel_b", 32'(bus.m_bready[0]), 1);
    exp0.push_back(2'b01);
    cyc();
    bus.m_bvalid[0] = 1'b0;
    chk("t4_b2b", 32'(bus.s_bvalid[0]), 1);
    cyc();
    cyc();
    chk("t4_cnt", 32'(ncnt), 13);

    // B from a slave with an empty queue
`ifdef WRESP_UNEXP_DROP_EN
    chk("t5_err_pre", 32'(unexp_b_err), 0);
    bus.m_bvalid[0] = 1'b1;
    #1 chk("t5_accept", 32'(bus.m_bready[0]), 1);
    cyc();
    bus.m_bvalid[0] = 1'b0;
    chk("t5_err", 32'(unexp_b_err), 1);
    chk("t5_no_route", 32'(bus.s_bvalid), 0);
    cyc();
    chk("t5_err_sticky", 32'(unexp_b_err), 1);
`else
    bus.m_bvalid[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1 chk("t5_stall", 32'(bus.m_bready[0]), 0);
      cyc();
    end
    bus.m_bvalid[0] = 1'b0;
`endif
    chk("t5_cnt", 32'(ncnt), 13);

    // Asynchronous reset mid-transfer
    bus.s_bready = 2'b00;
    push(0, 0);
    push(1, 0);
    push(0, 1);
    push(1, 1);
    bus.m_bvalid[0] = 1'b1;
    bus.m_bresp[1:0] = 2'b11;
    cyc();
    bus.m_bvalid[0] = 1'b0;
    chk("t6_held", 32'(bus.s_bvalid[0]), 1);
    #2 reset_n = 1'b0;
`ifndef WRESP_UNEXP_DROP_EN
    bus.m_bvalid = 2'b11;
`endif
    #1;
    chk("t6_svalid", 32'(bus.s_bvalid), 0);
    chk("t6_sresp", 32'(bus.s_bresp), 0);
    chk("t6_cnt", 32'(ncnt), 0);
    chk("t6_qfull", 32'(qfull), 0);
    chk("t6_mready", 32'(bus.m_bready), 0);
`ifdef WRESP_UNEXP_DROP_EN
    chk("t6_err", 32'(unexp_b_err), 0);
`endif
    bus.m_bvalid = 2'b00;
    cyc();
    reset_n = 1'b1;
    bus.s_bready = 2'b11;
    cyc();
    bus.m_bvalid[0] = 1'b1;
    bus.m_bresp[1:0] = 2'b00;
    for (int i = 0; i < 3; i++) begin
`ifndef WRESP_UNEXP_DROP_EN
      #1 chk("t6_post_mready", 32'(bus.m_bready[0]), 0);
`endif
      cyc();
      chk("t6_post_svalid", 32'(bus.s_bvalid), 0);
    end
    bus.m_bvalid[0] = 1'b0;
    cyc();
    chk("t6_post_cnt", 32'(ncnt), 0);

    chk("sb_m0_left", exp0.size(), 0);
    chk("sb_m1_left", exp1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/write_resp_controller.md
WRITE_RESP_CONTROLLER -- requirements
Module: write_resp_controller

Interface
REQ-001 Parameter NUM_MASTERS, default 2, number of upstream masters.
REQ-002 Parameter NUM_SLAVES, default 2, number of downstream slaves.
REQ-003 Parameter ID_W, default $clog2(NUM_SLAVES), slave index width; MID_W, default $clog2(NUM_MASTERS), master index width.
REQ-004 Parameter QDEPTH, default 4, per-slave outstanding-write queue depth, power of two ≥ 2.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 aw_push  input  1  one AW handshake completed to a slave this cycle.
REQ-008 aw_push_master  input  MID_W  index of the granted master.
REQ-009 aw_push_slave  input  ID_W  index of the selected slave.
REQ-010 Queue_Is_Full  output  1  high when any slave queue holds QDEPTH entries.
REQ-011 m_bresp  input  NUM_SLAVES×2  per-slave B response.
REQ-012 m_bvalid  input  NUM_SLAVES  per-slave B valid.
REQ-013 m_bready  output  NUM_SLAVES  per-slave B ready.
REQ-014 s_bresp  output  NUM_MASTERS×2  per-master routed response.
REQ-015 s_bvalid  output  NUM_MASTERS  per-master routed valid.
REQ-016 s_bready  input  NUM_MASTERS  per-master ready.
REQ-017 Num_Of_Compl_Bursts  output  4  total completed B handshakes toward masters, wraps modulo 16.

Function
REQ-018 aw_push SHALL write aw_push_master into the queue of slave aw_push_slave; a push to a full queue SHALL be ignored, with no pointer or count change.
REQ-019 Queue_Is_Full SHALL reflect register state at cycle start, not same-cycle pops.
REQ-020 Queue head of slave s names the master owed the next B from s; B responses SHALL be routed in AW order per slave.
REQ-021 Each master SHALL own a one-entry output register (s_bvalid/s_bresp); it is free when empty or when s_bvalid&&s_bready this cycle.
REQ-022 For each master, the candidates are the slaves with m_bvalid high, a non-empty queue, and head == that master; one winner per master SHALL be chosen round-robin, starting after the last winner.
REQ-023 m_bready[s] SHALL be high only for a winner whose target register is free; it is combinational from registered state and m_bvalid.
REQ-024 On m_bvalid[s]&&m_bready[s] the queue of s SHALL pop, the target register SHALL load m_bresp[s] with s_bvalid high the next cycle, and that master's RR pointer SHALL advance past s. Latency slave→master is 1 cycle.
REQ-025 s_bvalid SHALL remain high and s_bresp stable until s_bready; reload in the same cycle as drain is allowed, giving full throughput.
REQ-026 A push and a pop on the same queue in one cycle SHALL both take effect. A push to an empty queue SHALL NOT be poppable until the next cycle.
REQ-027 Pointers SHALL be log2(QDEPTH)+1 bits; full/empty SHALL come from MSB comparison, so the queue wraps cleanly.
REQ-028 Num_Of_Compl_Bursts SHALL increment once per master-side handshake; simultaneous handshakes on k masters SHALL add k.

Reset
REQ-029 When reset_n is low, all queues SHALL be empty, s_bvalid=0, s_bresp=0, RR pointers=0, and Num_Of_Compl_Bursts=0; m_bready=0 and Queue_Is_Full=0 follow from this state.
REQ-030 Reset mid-transfer SHALL discard all pending entries and held responses, with no replay after release.

Configuration
REQ-031 With WRESP_UNEXP_DROP_EN defined, a B from a slave whose queue is empty SHALL be accepted (m_bready=1), discarded, and SHALL set a sticky output unexp_b_err, cleared only by reset.
REQ-032 Without WRESP_UNEXP_DROP_EN, such a B SHALL see m_bready=0 indefinitely, and no unexp_b_err port exists.

Structure
REQ-033 A shared package SHALL hold the BRESP encodings (OKAY/EXOKAY/SLVERR/DECERR) and the queue-pointer typedef.
REQ-034 The per-slave queue SHALL be one sub-module, wresp_order_fifo, instantiated NUM_SLAVES times.

Verification
REQ-035 Push (M1→S0), then S0 bvalid with bresp=2'b00 -> m_bready[0]=1 the same cycle; s_bvalid[1]=1 and s_bresp[1]=00 the next cycle; count becomes 1.
REQ-036 Four pushes to S1 -> Queue_Is_Full=1; a fifth push is ignored; after one B pop, Queue_Is_Full=0 the following cycle.
REQ-037 Queues S0 and S1 both have head M0, both bvalid high -> S0 is granted first, S1 in the next free cycle; the RR pointer alternates on the next contention.
REQ-038 s_bready[0]=0 for 5 cycles while the register is full -> s_bresp is held stable and m_bready to M0's winner stays 0; on release, back-to-back drain with 1 per cycle.
REQ-039 S0 bvalid with an empty queue -> with the macro: accepted, unexp_b_err=1; without it: m_bready[0] stays 0 for 20 cycles.
REQ-040 reset_n pulsed low with 3 entries queued and s_bvalid high -> all outputs return to reset values asynchronously; post-reset S0 bvalid is not routed.
